search_crpr_capture: RTL and testbench
======================================

// Module: search_crpr_capture
//
// PURPOSE
// Downstream capture stage for the reconvergent-clock register pair's serial
// output (out1). Deserialises qualified bits into WIDTH-bit words, presents
// each word on a single-entry valid/ready holding register, and flags words
// dropped under back-pressure. Runs in the same clock domain as the capture
// register reg2, so sampling is single-cycle with no synchroniser.
//
// PARAMETERS
// WIDTH      8  bits per assembled word; legal range 2..32
// MSB_FIRST  0  0: first accepted bit -> word bit 0; 1: first bit -> bit WIDTH-1
//
// PORTS
// clk        input   1                 clock, rising edge
// rst        input   1                 reset, synchronous, active-high
// in_bit     input   1                 serial data bit (driven by out1)
// in_en      input   1                 in_bit is qualified this cycle
// word_data  output  WIDTH             assembled word; stable while word_valid=1
// word_valid output  1                 holding register is full
// word_ready input   1                 consumer accepts word_data this cycle
// overflow   output  1                 sticky: a completed word was dropped
// bit_count  output  $clog2(WIDTH)     bits collected toward the current word
//
// BEHAVIOUR
// - Reset (rst=1 at a clk edge): shift reg=0, bit_count=0, word_data=0,
//   word_valid=0, overflow=0. rst overrides all other inputs that edge.
// - in_en=0: shift register and bit_count hold; no other state changes.
// - in_en=1 and bit_count<WIDTH-1: bit shifts in; bit_count+1.
// - in_en=1 and bit_count==WIDTH-1 ("completion"): word = collected bits + this
//   bit; bit_count wraps to 0 the same edge, whether or not the word is kept.
// - Bit ordering: MSB_FIRST=0 -> k-th accepted bit (k=0..WIDTH-1) is word[k];
//   MSB_FIRST=1 -> it is word[WIDTH-1-k].
// - Latency: word_data/word_valid update on the completion edge (visible the
//   cycle after the last bit is presented). No combinational in->out paths.
// - Handshake: transfer when word_valid & word_ready at a clk edge. word_valid
//   stays 1 and word_data is held until transfer. word_ready while
//   word_valid=0 is ignored.
// - Holding register update per edge (priority order):
//   completion & (!word_valid | word_ready): load word, word_valid=1;
//   completion & word_valid & !word_ready: word dropped, old word kept,
//     overflow set to 1;
//   no completion & transfer: word_valid=0 (word_data keeps last value);
//   otherwise hold.
// - Simultaneous transfer + completion: new word replaces old, word_valid stays
//   1 (no bubble), overflow unchanged.
// - overflow clears only on rst.
// - rst mid-word discards the partial word; the next WIDTH qualified bits form
//   a clean word.
// - One shift register, one counter, one holding register; no further state.
//
// TESTING
// 1. rst=1 two cycles, in_en toggling -> word_valid=0, word_data=0, overflow=0,
//    bit_count=0 throughout and one cycle after rst falls.
// 2. WIDTH=8, MSB_FIRST=0, word_ready=1, in_en=1 with bits 1,0,1,1,0,0,1,0 ->
//    word_valid=1 for exactly one cycle with word_data=8'h4D; bit_count back to 0.
// 3. MSB_FIRST=1, same bits, with in_en=0 gaps of 1-3 cycles between bits ->
//    word_data=8'hB2; bit_count holds through gaps.
// 4. word_ready=0; send 8'h4D then 8'h0F -> word_data stays 8'h4D, overflow=1
//    after 2nd completion; then word_ready=1 one cycle -> word_valid=0,
//    overflow stays 1.
// 5. Hold 8'h4D unaccepted; assert word_ready on the 8'h0F completion edge ->
//    word_valid stays 1, word_data=8'h0F, overflow=0.
// 6. Send 5 bits, pulse rst, then send 8'hA5 -> bit_count=0 after rst, single
//    word 8'hA5, overflow=0.

Source files
------------

// File: rtl/search_crpr_capture.sv
// Capture stage for the reconvergent-clock register pair's serial output.
// Assembles qualified serial bits into WIDTH-bit words and offers each word
// on a single-entry valid/ready holding register. A word that completes while
// the holding register is still full is dropped, and a sticky overflow flag is set.
module search_crpr_capture #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_bit,
    input  logic                     in_en,
    output logic [WIDTH-1:0]         word_data,
    output logic                     word_valid,
    input  logic                     word_ready,
    output logic                     overflow,
    output logic [$clog2(WIDTH)-1:0] bit_count
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] shifted;
    logic             complete;

    // After WIDTH shifts, the direction of the shift places the first bit
    // at bit 0 (right shift) or at bit WIDTH-1 (left shift).
    always_comb begin
        if (MSB_FIRST) begin
            shifted = {shift_q[WIDTH-2:0], in_bit};
        end else begin
            shifted = {in_bit, shift_q[WIDTH-1:1]};
        end
    end

    assign complete = in_en && (cnt_q == LAST);

    // Shift register and bit counter next state
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (in_en) begin
            if (complete) begin
                shift_d = '0;
                cnt_d   = '0;
            end else begin
                shift_d = shifted;
                cnt_d   = cnt_q + CW'(1);
            end
        end
    end

    // Holding register: a completed word loads if the slot is free or is being
    // transferred this edge. Otherwise the word is dropped and overflow is flagged.
    always_comb begin
        word_d  = word_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        if (complete) begin
            if (!valid_q || word_ready) begin
                word_d  = shifted;
                valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (valid_q && word_ready) begin
            valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign word_data  = word_q;
    assign word_valid = valid_q;
    assign overflow   = ovf_q;
    assign bit_count  = cnt_q;

endmodule

// File: tb/tb_search_crpr_capture.sv
// Directed bench for search_crpr_capture. Two instances share all inputs:
// u_lsb (MSB_FIRST=0) and u_msb (MSB_FIRST=1).
module tb_search_crpr_capture;

    logic       clk = 1'b0;
    logic       rst, in_bit, in_en, word_ready;
    logic [7:0] data0, data1;
    logic       valid0, valid1, ovf0, ovf1;
    logic [2:0] cnt0, cnt1;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    search_crpr_capture #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .in_bit(in_bit), .in_en(in_en),
        .word_data(data0), .word_valid(valid0), .word_ready(word_ready),
        .overflow(ovf0), .bit_count(cnt0)
    );

    search_crpr_capture #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .in_bit(in_bit), .in_en(in_en),
        .word_data(data1), .word_valid(valid1), .word_ready(word_ready),
        .overflow(ovf1), .bit_count(cnt1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge; outputs are then sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        in_en  = 1'b1;
        in_bit = b;
        tick();
        in_en  = 1'b0;
    endtask

    // Sends the first n bits of w, starting at w[0].
    task automatic send_bits(input logic [7:0] w, input int unsigned n);
        for (int unsigned k = 0; k < n; k++) send_bit(w[k]);
    endtask

    initial begin
        logic [7:0] pat;
        rst = 1'b1; in_bit = 1'b1; in_en = 1'b0; word_ready = 1'b0;

        // 1. reset with in_en toggling
        for (int i = 0; i < 2; i++) begin
            in_en = (i == 0);
            tick();
            check("rst_valid", valid0, 0);
            check("rst_data", data0, 8'h00);
            check("rst_ovf", ovf0, 0);
            check("rst_cnt", cnt0, 0);
            check("rst_cnt_msb", cnt1, 0);
        end
        rst = 1'b0; in_en = 1'b0;
        tick();
        check("post_rst_valid", valid0, 0);
        check("post_rst_data", data0, 8'h00);
        check("post_rst_ovf", ovf0, 0);
        check("post_rst_cnt", cnt0, 0);

        // 2. LSB first, back-to-back bits 1,0,1,1,0,0,1,0
        word_ready = 1'b1;
        pat = 8'h4D;
        for (int unsigned k = 0; k < 7; k++) begin
            send_bit(pat[k]);
            check("t2_cnt", cnt0, k + 1);
            check("t2_valid_low", valid0, 0);
        end
        send_bit(pat[7]);
        check("t2_valid", valid0, 1);
        check("t2_data", data0, 8'h4D);
        check("t2_cnt_wrap", cnt0, 0);
        tick();
        check("t2_valid_one_cycle", valid0, 0);
        check("t2_data_kept", data0, 8'h4D);

        // 3. same bits with gaps of 1..3 idle cycles
        for (int unsigned k = 0; k < 8; k++) begin
            send_bit(pat[k]);
            if (k < 7) begin
                for (int unsigned g = 0; g < (k % 3) + 1; g++) begin
                    tick();
                    check("t3_cnt_hold", cnt1, k + 1);
                end
            end
        end
        check("t3_valid_msb", valid1, 1);
        check("t3_data_msb", data1, 8'hB2);
        check("t3_data_lsb", data0, 8'h4D);
        check("t3_cnt_wrap", cnt1, 0);
        tick();
        check("t3_valid_drop", valid1, 0);

        // 4. back-pressure: second word dropped
        word_ready = 1'b0;
        send_bits(8'h4D, 8);
        check("t4_valid1", valid0, 1);
        check("t4_data1", data0, 8'h4D);
        check("t4_ovf_clear", ovf0, 0);
        send_bits(8'h0F, 8);
        check("t4_data_kept", data0, 8'h4D);
        check("t4_ovf_set", ovf0, 1);
        check("t4_valid_held", valid0, 1);
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        check("t4_valid_xfer", valid0, 0);
        check("t4_ovf_sticky", ovf0, 1);
        tick();
        check("t4_ovf_sticky2", ovf0, 1);

        // 5. completion coinciding with transfer
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_ovf_rst", ovf0, 0);
        send_bits(8'h4D, 8);
        check("t5_valid_hold", valid0, 1);
        send_bits(8'h0F, 7);
        check("t5_data_hold", data0, 8'h4D);
        word_ready = 1'b1;
        send_bit(1'b0);
        check("t5_valid_nobubble", valid0, 1);
        check("t5_data_new", data0, 8'h0F);
        check("t5_ovf", ovf0, 0);
        tick();
        check("t5_valid_drain", valid0, 0);

        // 6. reset mid-word
        send_bits(8'hFF, 5);
        check("t6_cnt_partial", cnt0, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_cnt_rst", cnt0, 0);
        check("t6_valid_rst", valid0, 0);
        send_bits(8'hA5, 7);
        check("t6_valid_low", valid0, 0);
        send_bit(1'b1);
        check("t6_valid", valid0, 1);
        check("t6_data", data0, 8'hA5);
        check("t6_ovf", ovf0, 0);
        check("t6_cnt", cnt0, 0);
        tick();
        check("t6_single", valid0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
